// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns the PC and keeps at most one instruction-memory request in flight
// over a valid/ready handshake. It drives the IF/ID register and obeys
// the hazard-detector stalls, EX redirects (flush) and halt.
// Optional build macro FETCH_PERF_CNT_EN adds the bubble/flush counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_write,
    input  logic        IF_ID_write,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] IF_ID_inst,
    output logic [31:0] IF_ID_pc,
    output logic        IF_ID_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        fetch_stall
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // no request outstanding
        S_WAIT  = 2'd1,  // one request outstanding
        S_HOLD  = 2'd2,  // response buffered, IF/ID not writable
        S_DRAIN = 2'd3   // outstanding response must be thrown away
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] r_hold_inst;
    logic [31:0] r_if_id_inst;
    logic [31:0] r_if_id_pc;
    logic        r_if_id_valid;
    logic        r_fetch_stall;
    logic        w_writable;
    logic        w_consume;
    logic        w_deliver;
    logic [31:0] w_deliver_inst;
    logic        w_hold_load;
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_accept;
    logic        w_bubble;

    // A PC_write=0 cycle is treated as a hold even if IF_ID_write is set.
    assign w_writable = IF_ID_write && PC_write;
    assign w_consume  = w_writable && !flush;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_accept   = w_req_valid && imem_req_ready;
    assign w_bubble   = w_writable && !flush && !w_deliver;

    // Request generation: fresh issue in REQ, back-to-back issue from WAIT.
    always_comb begin
        w_req_valid = 1'b0;
        w_req_addr  = r_pc;
        if (r_state == S_REQ) begin
            w_req_valid = !halt && !reset;
            w_req_addr  = r_pc;
        end else if ((r_state == S_WAIT) && imem_resp_valid && w_consume) begin
            w_req_valid = !halt && !reset;
            w_req_addr  = w_pc_plus4;
        end else begin
            w_req_valid = 1'b0;
            w_req_addr  = r_pc;
        end
    end

    // Next-state, PC update and delivery selection; flush overrides everything.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_deliver      = 1'b0;
        w_deliver_inst = imem_resp_data;
        w_hold_load    = 1'b0;
        if (flush) begin
            w_pc_nxt = redirect_pc;
            if ((((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_resp_valid) || w_accept) begin
                w_state_nxt = S_DRAIN;
            end else begin
                w_state_nxt = S_REQ;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid && w_consume) begin
                        w_deliver = 1'b1;
                        w_pc_nxt  = w_pc_plus4;
                        if (w_accept) begin
                            w_state_nxt = S_WAIT;
                        end else begin
                            w_state_nxt = S_REQ;
                        end
                    end else if (imem_resp_valid) begin
                        w_hold_load = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (w_consume) begin
                        w_deliver      = 1'b1;
                        w_deliver_inst = r_hold_inst;
                        w_pc_nxt       = w_pc_plus4;
                        w_state_nxt    = S_REQ;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                default: begin
                    w_state_nxt = S_REQ;
                end
            endcase
        end
    end

    // State, PC and hold-buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_hold_inst <= NOP_INST;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_hold_load) begin
                r_hold_inst <= imem_resp_data;
            end
        end
    end

    // IF/ID register: flush bubble, real instruction, stall bubble, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_id_inst  <= NOP_INST;
            r_if_id_pc    <= 32'h0000_0000;
            r_if_id_valid <= 1'b0;
            r_fetch_stall <= 1'b0;
        end else if (flush) begin
            r_if_id_inst  <= NOP_INST;
            r_if_id_pc    <= redirect_pc;
            r_if_id_valid <= 1'b0;
            r_fetch_stall <= 1'b0;
        end else if (w_deliver) begin
            r_if_id_inst  <= w_deliver_inst;
            r_if_id_pc    <= r_pc;
            r_if_id_valid <= 1'b1;
            r_fetch_stall <= 1'b0;
        end else if (w_bubble) begin
            r_if_id_inst  <= NOP_INST;
            r_if_id_pc    <= r_pc;
            r_if_id_valid <= 1'b0;
            r_fetch_stall <= 1'b1;
        end else begin
            r_fetch_stall <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating counters of bubble cycles and flush cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= 32'h0000_0000;
            r_flush_cnt  <= 32'h0000_0000;
        end else begin
            if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_bubble_cnt = r_bubble_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
`endif

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = w_req_addr;
    assign IF_ID_inst     = r_if_id_inst;
    assign IF_ID_pc       = r_if_id_pc;
    assign IF_ID_valid    = r_if_id_valid;
    assign fetch_stall    = r_fetch_stall;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: memory model plus scoreboard of
// presented responses, checked against IF/ID every cycle.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_write;
    logic        IF_ID_write;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] IF_ID_inst;
    logic [31:0] IF_ID_pc;
    logic        IF_ID_valid;
    logic        fetch_stall;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk             (clk),
        .reset           (reset),
        .PC_write        (PC_write),
        .IF_ID_write     (IF_ID_write),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .IF_ID_inst      (IF_ID_inst),
        .IF_ID_pc        (IF_ID_pc),
        .IF_ID_valid     (IF_ID_valid),
`ifdef FETCH_PERF_CNT_EN
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
`endif
        .fetch_stall     (fetch_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat     = 1;
    logic        pend    = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt  = 0;
    logic        drop      = 1'b0;
    logic [31:0] exp_pc    = RST_PC;
    logic        obs_req_valid, obs_acc;
    logic [31:0] obs_req_addr;
    logic        c_rst, c_resp, c_flush, c_del, c_wr;
    logic [31:0] c_redir;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_addr = 32'h0;
    logic [31:0] p_inst, p_pc;
    logic        p_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd7) ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle: sample/update model at negedge, check IF/ID after posedge.
    task automatic cyc();
        ent_t e;
        @(negedge clk);
        obs_req_valid = imem_req_valid;
        obs_req_addr  = imem_req_addr;
        obs_acc       = imem_req_valid && imem_req_ready;
        c_rst   = reset;
        c_resp  = imem_resp_valid;
        c_flush = flush;
        c_redir = redirect_pc;
        c_wr    = IF_ID_write && PC_write;
        c_del   = 1'b0;
        p_inst  = IF_ID_inst;
        p_pc    = IF_ID_pc;
        p_valid = IF_ID_valid;
        if (!reset) begin
            if (stall_prev) begin
                chk("req_stable_valid", {31'd0, imem_req_valid}, 32'd1);
                chk("req_stable_addr", imem_req_addr, stall_addr);
            end
            if (imem_resp_valid) begin
                if (!drop && !flush) begin
                    sb.push_back('{pend_addr, imem_resp_data});
                end
                drop = 1'b0;
            end
            if (flush) begin
                sb.delete();
                exp_pc = redirect_pc;
                if (obs_acc || (pend && !imem_resp_valid)) drop = 1'b1;
            end
            c_del      = c_wr && !flush && (sb.size() > 0);
            stall_prev = imem_req_valid && !imem_req_ready && !flush;
            stall_addr = imem_req_addr;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        if (c_rst) begin
            pend = 1'b0;
        end else begin
            if (c_resp) pend = 1'b0;
            if (obs_acc) begin
                pend      = 1'b1;
                pend_addr = obs_req_addr;
                pend_cnt  = lat - 1;
            end else if (pend && (pend_cnt > 0)) begin
                pend_cnt--;
            end
        end
        imem_resp_valid = pend && (pend_cnt == 0);
        imem_resp_data  = pend ? mem_word(pend_addr) : 32'h0;
        if (!c_rst) begin
            if (c_flush) begin
                chk("flush_valid", {31'd0, IF_ID_valid}, 32'd0);
                chk("flush_pc", IF_ID_pc, c_redir);
                chk("flush_inst", IF_ID_inst, NOP);
                chk("flush_stall", {31'd0, fetch_stall}, 32'd0);
            end else if (c_del) begin
                e = sb.pop_front();
                chk("del_valid", {31'd0, IF_ID_valid}, 32'd1);
                chk("del_pc", IF_ID_pc, e.pc);
                chk("del_inst", IF_ID_inst, e.inst);
                chk("del_pc_seq", IF_ID_pc, exp_pc);
                chk("del_stall", {31'd0, fetch_stall}, 32'd0);
                exp_pc = exp_pc + 32'd4;
            end else if (c_wr) begin
                chk("bub_valid", {31'd0, IF_ID_valid}, 32'd0);
                chk("bub_inst", IF_ID_inst, NOP);
                chk("bub_pc", IF_ID_pc, exp_pc);
                chk("bub_stall", {31'd0, fetch_stall}, 32'd1);
            end else begin
                chk("hold_valid", {31'd0, IF_ID_valid}, {31'd0, p_valid});
                chk("hold_pc", IF_ID_pc, p_pc);
                chk("hold_inst", IF_ID_inst, p_inst);
                chk("hold_stall", {31'd0, fetch_stall}, 32'd0);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; halt = 1'b0;
        IF_ID_write = 1'b1; PC_write = 1'b1; imem_req_ready = 1'b1;
        cyc();
        reset = 1'b0;
        sb.delete();
        drop = 1'b0;
        exp_pc = RST_PC;
        lat = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_pc;
        logic        seen;
        reset = 1'b1; flush = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
        IF_ID_write = 1'b1; PC_write = 1'b1; imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;

        // Reset state
        cyc();
        chk("rst_inst", IF_ID_inst, NOP);
        chk("rst_pc", IF_ID_pc, 32'h0);
        chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
        chk("rst_req", {31'd0, obs_req_valid}, 32'd0);
        reset = 1'b0;

        // Zero-wait streaming
        cyc();
        chk("first_req_valid", {31'd0, obs_req_valid}, 32'd1);
        chk("first_req_addr", obs_req_addr, RST_PC);
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", {31'd0, IF_ID_valid}, 32'd1);
            chk("stream_pc", IF_ID_pc, RST_PC + 32'(4 * i));
            cyc();
        end

        // Response arrives while stalled for 2 cycles
        IF_ID_write = 1'b0; PC_write = 1'b0;
        held_pc = IF_ID_pc;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("stall_noreq", {31'd0, obs_req_valid}, 32'd0);
            chk("stall_if_pc", IF_ID_pc, held_pc);
        end
        IF_ID_write = 1'b1; PC_write = 1'b1;
        cyc();
        chk("release_valid", {31'd0, IF_ID_valid}, 32'd1);
        chk("release_pc", IF_ID_pc, held_pc + 32'd4);
        cyc();
        chk("release_next_addr", obs_req_addr, held_pc + 32'd8);
        for (int i = 0; i < 3; i++) cyc();

        // Memory not ready for 3 cycles on the first request
        do_reset();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("nr_req_valid", {31'd0, obs_req_valid}, 32'd1);
            chk("nr_req_addr", obs_req_addr, 32'h0);
            chk("nr_stall", {31'd0, fetch_stall}, 32'd1);
            chk("nr_inst", IF_ID_inst, 32'h13);
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();

        // Flush while a slow request is in flight
        lat = 3;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            if (pend && !imem_resp_valid) seen = 1'b1;
        end
        chk("wait_reached", {31'd0, seen}, 32'd1);
        flush = 1'b1; redirect_pc = 32'h100;
        cyc();
        flush = 1'b0;
        chk("redir_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("redir_pc", IF_ID_pc, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            if (obs_req_valid) begin
                seen = 1'b1;
                chk("redir_addr", obs_req_addr, 32'h100);
            end
        end
        chk("redir_req_seen", {31'd0, seen}, 32'd1);
        lat = 1;
        for (int i = 0; i < 8; i++) cyc();

        // Halt with a request outstanding
        halt = 1'b1;
        cyc();
        chk("halt_deliver", {31'd0, IF_ID_valid}, 32'd1);
        chk("halt_noreq0", {31'd0, obs_req_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("halt_noreq", {31'd0, obs_req_valid}, 32'd0);
        end
        halt = 1'b0;
        cyc();
        chk("unhalt_req", {31'd0, obs_req_valid}, 32'd1);
        chk("unhalt_addr", obs_req_addr, IF_ID_pc);
        for (int i = 0; i < 4; i++) cyc();

`ifdef FETCH_PERF_CNT_EN
        // Performance counters: 2 flushes then 3 bubbles, then reset
        do_reset();
        chk("perf_rst_b", perf_bubble_cnt, 32'd0);
        chk("perf_rst_f", perf_flush_cnt, 32'd0);
        IF_ID_write = 1'b0; PC_write = 1'b0; imem_req_ready = 1'b0;
        flush = 1'b1; redirect_pc = 32'h200;
        cyc(); cyc();
        flush = 1'b0;
        IF_ID_write = 1'b1; PC_write = 1'b1;
        cyc(); cyc(); cyc();
        IF_ID_write = 1'b0; PC_write = 1'b0;
        cyc();
        chk("perf_bubble", perf_bubble_cnt, 32'd3);
        chk("perf_flush", perf_flush_cnt, 32'd2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("perf_rst2_b", perf_bubble_cnt, 32'd0);
        chk("perf_rst2_f", perf_flush_cnt, 32'd0);
        do_reset();
        for (int i = 0; i < 4; i++) cyc();
`endif

        // Let the pipe settle; nothing may stay pending in the scoreboard
        halt = 1'b1; IF_ID_write = 1'b1; PC_write = 1'b1; imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage pipelined RV32I core. It owns the PC, issues at most one outstanding request to instruction memory over a valid/ready handshake, and drives the IF/ID pipeline register. It sits directly upstream of the hazard detector and obeys that block's `PC_write`/`IF_ID_write` stall controls. It also accepts redirect/flush from EX and halt after ecall.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset
- `NOP_INST`, default 32'h0000_0013, encoding loaded into IF/ID on bubble/flush (addi x0,x0,0)
- `clk  input  1  clock; all state updates on rising edge`
- `reset  input  1  synchronous, active-high reset`
- `PC_write  input  1  from hazard detector; 0 = PC must not advance`
- `IF_ID_write  input  1  from hazard detector; 0 = IF/ID register holds`
- `flush  input  1  redirect request from EX (taken branch / jump mispredict)`
- `redirect_pc  input  32  target PC, valid with flush`
- `halt  input  1  level; while 1 no new imem requests are issued`
- `imem_req_valid  output  1  request valid`
- `imem_req_addr  output  32  request address, word aligned`
- `imem_req_ready  input  1  memory accepts request this cycle`
- `imem_resp_valid  input  1  response data valid (one per accepted request, in order)`
- `imem_resp_data  input  32  fetched instruction`
- `IF_ID_inst  output  32  registered instruction to ID`
- `IF_ID_pc  output  32  registered PC of IF_ID_inst`
- `IF_ID_valid  output  1  1 = IF_ID_inst is a real instruction`
- `fetch_stall  output  1  1 = IF/ID was writable but no instruction was available (bubble inserted)`

## Operation
- States: REQ (no outstanding request), WAIT (one outstanding), HOLD (response buffered, IF/ID not writable), DRAIN (outstanding response to be discarded).
- Consume condition: `IF_ID_write && PC_write && !flush`. `IF_ID_write=1, PC_write=0` is treated as a hold; the hazard detector never produces it.
- REQ: `imem_req_valid = !halt && !reset`, addr = pc. Accepted with ready → WAIT.
- WAIT: on resp_valid, if consume: IF/ID ← {data, pc, valid=1}, pc ← pc+4. Back-to-back issue is allowed: in the same cycle, `imem_req_valid = !halt` with addr = pc+4. If that request is accepted, stay in WAIT; otherwise go to REQ. If not consume: data and pc go to the hold buffer → HOLD.
- HOLD: no requests. When consume: IF/ID ← hold buffer, pc ← pc+4 → REQ.
- When IF/ID is writable and no instruction is delivered that cycle: IF/ID ← {NOP_INST, pc, valid=0}, fetch_stall=1.
- Flush (highest priority, any state): pc ← redirect_pc; IF/ID ← {NOP_INST, redirect_pc, 0}; hold buffer dropped. If a request is outstanding, or is accepted in the flush cycle → DRAIN; otherwise → REQ.
- DRAIN: no requests. The next resp_valid is discarded → REQ. A flush during DRAIN updates pc and stays in DRAIN.
- halt does not cancel an outstanding request. Its response is consumed normally.

## Timing
- Reset values: pc=RESET_PC, state=REQ, IF_ID_inst=NOP_INST, IF_ID_pc=0, IF_ID_valid=0, imem_req_valid=0, fetch_stall=0.
- First request is presented in the cycle after reset deasserts.
- With zero-wait memory (ready=1, response one cycle after acceptance), the stage sustains 1 instruction/cycle after a 2-cycle startup.
- Fetch latency: request cycle N, response cycle N+1, IF/ID updated at the end of N+1.
- `imem_req_addr` is stable while valid=1 and ready=0. Valid never drops without acceptance, except on flush or reset.
- Combinational path `imem_resp_valid`/`IF_ID_write` → `imem_req_valid` exists by design.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `perf_bubble_cnt` (32) and `perf_flush_cnt` (32).
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - `perf_bubble_cnt` increments each cycle fetch_stall=1.
  - `perf_flush_cnt` increments each flush cycle.
- Undefined: those ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Zero-wait memory, RESET_PC=0 → IF_ID_pc sequence 0,4,8,… on consecutive cycles from cycle 2, with IF_ID_valid=1.
- Memory ready=0 for 3 cycles on the first request → imem_req_addr held at 0; fetch_stall=1 and IF_ID_inst=32'h13 each bubble cycle.
- Response arrives while IF_ID_write=PC_write=0 for 2 cycles → no new request; IF/ID unchanged. On release, the buffered instruction enters IF/ID and pc advances by 4.
- flush with redirect_pc=32'h100 while in WAIT → the in-flight response is discarded, IF_ID_valid=0 next cycle, and the next request address is 32'h100.
- halt=1 with a request outstanding → the response is delivered and no further imem_req_valid appears until halt=0.
- With FETCH_PERF_CNT_EN: 3 bubbles and 2 flushes → perf_bubble_cnt=3, perf_flush_cnt=2. Reset mid-run → both 0 next cycle.
